jt7759_fetch: RTL and testbench

Byte-fetch scheduler between the JT7759 decoder control unit and the two sample-data sources. In master mode (mdn=1) it sequences ROM reads. In slave mode (mdn=0) it runs the drqn/write handshake with the host CPU. It gives the control unit one uniform request/acknowledge byte port and handles flushes when a new phrase starts.

---
 rtl/jt7759_fetch.sv | 218 +++++++++++++++++++++
 tb/tb_jt7759_fetch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt7759_fetch.sv
// JT7759 byte-fetch scheduler: ROM reads (master) or drqn/write handshake (slave).
// Optional one-entry next-address prefetch buffer: define JT7759_FETCH_PREFETCH_EN.
module jt7759_fetch #(
  parameter logic [4:0] DRQ_GAP = 5'd31
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cen_ctl,
  input  logic        mdn,
  input  logic        req_cs,
  input  logic [16:0] req_addr,
  input  logic        req_flush,
  output logic [7:0]  req_data,
  output logic        req_ok,
  output logic        rom_cs,
  output logic [16:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok,
  input  logic        cs,
  input  logic        wrn,
  input  logic [7:0]  din,
  output logic        drqn
);

`ifdef JT7759_FETCH_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, ROM_WAIT, DRQ_WAIT, HOLD, PREF} state_t;
`else
  typedef enum logic [1:0] {IDLE, ROM_WAIT, DRQ_WAIT, HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic        req_ok_q, req_ok_d;
  logic [7:0]  req_data_q, req_data_d;
  logic        rom_cs_q, rom_cs_d;
  logic [16:0] rom_addr_q, rom_addr_d;
  logic        drqn_q, drqn_d;
  logic [4:0]  gap_q, gap_d;
  logic        wr_q, wr_d;
  logic        first_q, first_d;
  logic        wr_now, wr_ev;
`ifdef JT7759_FETCH_PREFETCH_EN
  logic        buf_vld_q, buf_vld_d;
  logic [16:0] buf_addr_q, buf_addr_d;
  logic [7:0]  buf_data_q, buf_data_d;
  logic        from_rom_q, from_rom_d;
`endif

  always_comb begin
    state_d    = state_q;
    req_ok_d   = req_ok_q;
    req_data_d = req_data_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    drqn_d     = drqn_q;
    gap_d      = gap_q;
    first_d    = 1'b0;
    wr_now     = cs & ~wrn;
    wr_ev      = wr_now & ~wr_q;
    wr_d       = wr_now;
`ifdef JT7759_FETCH_PREFETCH_EN
    buf_vld_d  = buf_vld_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    from_rom_d = from_rom_q;
`endif
    if (cen_ctl && drqn_q && gap_q != 5'd0) gap_d = gap_q - 5'd1;

    // first_q marks the opening ROM cycle, where rom_ok may still belong to the old address
    case (state_q)
      IDLE: begin
        if (req_cs) begin
          if (mdn) begin
`ifdef JT7759_FETCH_PREFETCH_EN
            from_rom_d = 1'b1;
            if (buf_vld_q && req_addr == buf_addr_q) begin
              req_ok_d   = 1'b1;
              req_data_d = buf_data_q;
              rom_addr_d = req_addr;
              state_d    = HOLD;
            end else begin
              rom_addr_d = req_addr;
              rom_cs_d   = 1'b1;
              first_d    = 1'b1;
              state_d    = ROM_WAIT;
            end
`else
            rom_addr_d = req_addr;
            rom_cs_d   = 1'b1;
            first_d    = 1'b1;
            state_d    = ROM_WAIT;
`endif
          end else begin
`ifdef JT7759_FETCH_PREFETCH_EN
            from_rom_d = 1'b0;
`endif
            state_d = DRQ_WAIT;
          end
        end
      end
      ROM_WAIT: begin
        if (rom_ok && !first_q) begin
          req_data_d = rom_data;
          req_ok_d   = 1'b1;
          rom_cs_d   = 1'b0;
          state_d    = HOLD;
        end
      end
      DRQ_WAIT: begin
        if (wr_ev) begin
          drqn_d     = 1'b1;
          req_data_d = din;
          req_ok_d   = 1'b1;
          state_d    = HOLD;
        end else if (cen_ctl && drqn_q && gap_q == 5'd0) begin
          drqn_d = 1'b0;
          gap_d  = DRQ_GAP;
        end
      end
      HOLD: begin
        if (!req_cs) begin
          req_ok_d = 1'b0;
          state_d  = IDLE;
`ifdef JT7759_FETCH_PREFETCH_EN
          if (from_rom_q) begin
            rom_addr_d = rom_addr_q + 17'd1;
            rom_cs_d   = 1'b1;
            first_d    = 1'b1;
            state_d    = PREF;
          end
`endif
        end
      end
`ifdef JT7759_FETCH_PREFETCH_EN
      PREF: begin
        // A request for another address abandons the prefetch; a matching one rides on it
        if (req_cs && mdn && req_addr != rom_addr_q) begin
          buf_vld_d  = 1'b0;
          rom_addr_d = req_addr;
          first_d    = 1'b1;
          state_d    = ROM_WAIT;
        end else if (req_cs && !mdn) begin
          buf_vld_d = 1'b0;
          rom_cs_d  = 1'b0;
          state_d   = IDLE;
        end else if (rom_ok && !first_q) begin
          buf_vld_d  = 1'b1;
          buf_addr_d = rom_addr_q;
          buf_data_d = rom_data;
          rom_cs_d   = 1'b0;
          if (req_cs) begin
            req_data_d = rom_data;
            req_ok_d   = 1'b1;
            state_d    = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (req_flush) begin
      state_d  = IDLE;
      rom_cs_d = 1'b0;
      drqn_d   = 1'b1;
      req_ok_d = 1'b0;
      gap_d    = '0;
      first_d  = 1'b0;
`ifdef JT7759_FETCH_PREFETCH_EN
      buf_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      req_ok_q   <= 1'b0;
      req_data_q <= '0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      drqn_q     <= 1'b1;
      gap_q      <= '0;
      wr_q       <= 1'b0;
      first_q    <= 1'b0;
`ifdef JT7759_FETCH_PREFETCH_EN
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      from_rom_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_ok_q   <= req_ok_d;
      req_data_q <= req_data_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      drqn_q     <= drqn_d;
      gap_q      <= gap_d;
      wr_q       <= wr_d;
      first_q    <= first_d;
`ifdef JT7759_FETCH_PREFETCH_EN
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      from_rom_q <= from_rom_d;
`endif
    end
  end

  assign req_ok   = req_ok_q;
  assign req_data = req_data_q;
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign drqn     = drqn_q;

endmodule

// File: tb/tb_jt7759_fetch.sv
// Self-checking bench for jt7759_fetch: directed table, corner sequences, random mix.
module tb_jt7759_fetch;
  localparam logic [4:0] GAP = 5'd31;

  logic        clk, rstn, cen_ctl, mdn, req_cs, req_flush;
  logic [16:0] req_addr;
  logic [7:0]  req_data;
  logic        req_ok, rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok, cs, wrn;
  logic [7:0]  din;
  logic        drqn;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  rom_mem [0:131071];
  int          rom_lat;
  logic        rom_force;
  logic [16:0] rom_cur;
  int          rom_age;
  int          cen_pct;
  int          ticks;
  logic [7:0]  last_data_m;
  bit          buf_vld_m;
  logic [16:0] buf_addr_m;

  typedef struct {
    logic        mdn;
    logic [16:0] addr;
    logic [7:0]  data;
    int          lat;
    int          exp_cyc;
  } vec_t;
  vec_t vt [6];

  jt7759_fetch #(.DRQ_GAP(GAP)) dut (
    .clk(clk), .rstn(rstn), .cen_ctl(cen_ctl), .mdn(mdn),
    .req_cs(req_cs), .req_addr(req_addr), .req_flush(req_flush),
    .req_data(req_data), .req_ok(req_ok),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .cs(cs), .wrn(wrn), .din(din), .drqn(drqn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] ref_v);
    n_cmp++;
    if (act !== ref_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, ref_v);
    end
  endtask

  // ROM answers rom_lat cycles after rom_cs rises for an address
  task automatic rom_drive();
    rom_ok   = rom_force || (rom_cs && rom_age >= 1 + rom_lat);
    rom_data = rom_ok ? rom_mem[rom_addr] : ~rom_mem[rom_addr];
  endtask

  task automatic tick();
    @(posedge clk);
    if (cen_ctl && ticks < 100000) ticks++;
    #1;
    if (rom_cs) begin
      if (rom_age > 0 && rom_addr == rom_cur) rom_age++;
      else begin
        rom_age = 1;
        rom_cur = rom_addr;
      end
    end else rom_age = 0;
    rom_drive();
    cen_ctl = ($urandom_range(0, 99) < cen_pct);
  endtask

  task automatic master_read(input logic [16:0] addr, input int lat, input int exp_cyc,
                             input bit wait_pref);
    bit          hit;
    int          k;
    logic [7:0]  exp_d;
    logic [16:0] nxt;
    hit = 1'b0;
`ifdef JT7759_FETCH_PREFETCH_EN
    hit = buf_vld_m && (addr == buf_addr_m);
`endif
    exp_d = rom_mem[addr];
    nxt = addr + 17'd1;
    rom_lat = lat;
    mdn = 1'b1;
    req_addr = addr;
    req_cs = 1'b1;
    tick();
    k = 1;
    if (!hit) begin
      check("m_rom_cs_c1", rom_cs, 1);
      check("m_rom_addr", rom_addr, addr);
    end
    while (!req_ok && k < 200) begin
      tick();
      k++;
    end
    check("m_latency", k, hit ? 1 : exp_cyc);
    check("m_data", req_data, exp_d);
    repeat ($urandom_range(0, 3)) tick();
    check("m_hold", {req_ok, req_data}, {1'b1, exp_d});
    check("m_drqn", drqn, 1);
    last_data_m = exp_d;
    req_cs = 1'b0;
    tick();
    check("m_release", req_ok, 0);
`ifdef JT7759_FETCH_PREFETCH_EN
    check("pf_issue", {rom_cs, rom_addr}, {1'b1, nxt});
    buf_vld_m = 1'b0;
    if (wait_pref) begin
      k = 0;
      while (rom_cs && k < 200) begin
        tick();
        k++;
      end
      check("pf_done", rom_cs, 0);
      buf_vld_m = 1'b1;
      buf_addr_m = nxt;
    end
`else
    if (wait_pref) k = 0;
`endif
  endtask

  task automatic slave_xfer(input logic [7:0] data, input int wr_delay);
    int k;
    int pk;
    bit p;
    mdn = 1'b0;
    req_cs = 1'b1;
    k = 0;
    pk = -1;
    // drqn may fall at the first cen tick in DRQ_WAIT once GAP ticks have passed since the last serve
    while (k < 3000) begin
      p = (k >= 1) && cen_ctl && (ticks >= int'(GAP));
      if (p && pk < 0) pk = k + 1;
      tick();
      k++;
      if (k == 1) mdn = 1'($urandom_range(0, 1));
      if (!drqn) break;
      if (pk >= 0 && k > pk + 2) break;
    end
    check("s_fall_cycle", k, pk);
    repeat (wr_delay) tick();
    check("s_wait", {drqn, req_ok}, 2'b00);
    cs = 1'b1;
    wrn = 1'b0;
    din = data;
    tick();
    ticks = 0;
    check("s_serve", {req_ok, req_data, drqn}, {1'b1, data, 1'b1});
    din = ~data;
    tick();
    cs = 1'b0;
    wrn = 1'b1;
    check("s_hold", {req_ok, req_data}, {1'b1, data});
    last_data_m = data;
    req_cs = 1'b0;
    tick();
    check("s_release", req_ok, 0);
    mdn = 1'b0;
  endtask

  initial begin
    int          lat;
    int          k;
    logic [16:0] a;
    logic [16:0] last_addr;

    for (int i = 0; i < 131072; i++) rom_mem[i] = 8'($urandom);
    vt[0] = '{1'b0, 17'h00000, 8'hA7, 0, 0};
    vt[1] = '{1'b0, 17'h00000, 8'h3C, 4, 0};
    vt[2] = '{1'b1, 17'h00123, 8'h5A, 2, 4};
    vt[3] = '{1'b1, 17'h00000, 8'h00, 1, 3};
    vt[4] = '{1'b1, 17'h1FFFF, 8'hC3, 0, 3};
    vt[5] = '{1'b1, 17'h0ABCD, 8'hFF, 5, 7};
    for (int i = 0; i < 6; i++) if (vt[i].mdn) rom_mem[vt[i].addr] = vt[i].data;

    rstn = 1'b0; cen_ctl = 1'b0; mdn = 1'b1; req_cs = 1'b1; req_flush = 1'b0;
    req_addr = 17'h00123; cs = 1'b0; wrn = 1'b1; din = '0;
    rom_force = 1'b0; rom_lat = 0; rom_age = 0; rom_cur = '0; cen_pct = 60;
    ticks = 100000; last_data_m = '0; buf_vld_m = 1'b0; buf_addr_m = '0; last_addr = '0;
    rom_drive();

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_req_ok", req_ok, 0);
      check("rst_rom_cs", rom_cs, 0);
      check("rst_drqn", drqn, 1);
      check("rst_rom_addr", rom_addr, 0);
    end
    rstn = 1'b1;
    req_cs = 1'b0;
    tick();
    check("post_rst", {req_ok, rom_cs, drqn, rom_addr, req_data}, {3'b001, 17'h0, 8'h00});
    ticks = 100000;

    for (int i = 0; i < 6; i++) begin
      if (vt[i].mdn) begin
        master_read(vt[i].addr, vt[i].lat, vt[i].exp_cyc, 1'b1);
        last_addr = vt[i].addr;
      end else begin
        slave_xfer(vt[i].data, vt[i].lat);
      end
    end

    // spurious host write in IDLE
    mdn = 1'b0; cs = 1'b1; wrn = 1'b0; din = 8'h11;
    tick();
    check("spur_write", {req_data, drqn, req_ok}, {last_data_m, 1'b1, 1'b0});
    cs = 1'b0; wrn = 1'b1;
    tick();

    // flush in ROM_WAIT, then a late rom_ok
    mdn = 1'b1; rom_lat = 20; req_addr = 17'h00777; req_cs = 1'b1;
    tick();
    tick();
    req_flush = 1'b1; req_cs = 1'b0;
    tick();
    req_flush = 1'b0; ticks = 100000; buf_vld_m = 1'b0;
    check("fl_rom_cs", {rom_cs, req_ok}, 2'b00);
    rom_force = 1'b1;
    rom_drive();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_late_ok", {req_ok, rom_cs, req_data}, {2'b00, last_data_m});
    end
    rom_force = 1'b0;
    rom_drive();

    // flush and request together: request starts one cycle later
    rom_lat = 20; req_addr = 17'h00042; req_cs = 1'b1; req_flush = 1'b1;
    tick();
    req_flush = 1'b0;
    check("fl_cs_both", rom_cs, 0);
    tick();
    check("fl_cs_next", {rom_cs, rom_addr}, {1'b1, 17'h00042});
    req_flush = 1'b1; req_cs = 1'b0;
    tick();
    req_flush = 1'b0; ticks = 100000; buf_vld_m = 1'b0;
    check("fl_cs_abort", rom_cs, 0);

    // slave flush with drqn low clears the gap counter
    mdn = 1'b0; req_cs = 1'b1; k = 0;
    while (drqn && k < 3000) begin
      tick();
      k++;
    end
    check("sfl_drqn_low", drqn, 0);
    req_flush = 1'b1; req_cs = 1'b0;
    tick();
    req_flush = 1'b0; ticks = 100000; buf_vld_m = 1'b0;
    check("sfl_after", {drqn, req_ok}, 2'b10);
    slave_xfer(8'h5C, 1);

`ifdef JT7759_FETCH_PREFETCH_EN
    master_read(17'h1FFFF, 1, 3, 1'b1);
    master_read(17'h00000, 6, 3, 1'b0);
    master_read(17'h00005, 2, 4, 1'b1);
    last_addr = 17'h00005;
`endif

    for (int t = 0; t < 40; t++) begin
      cen_pct = $urandom_range(30, 100);
      if ($urandom_range(0, 1) == 1) begin
        lat = $urandom_range(0, 4);
        a = ($urandom_range(0, 3) == 0) ? last_addr + 17'd1 : 17'($urandom);
        master_read(a, lat, (lat >= 1) ? 2 + lat : 3, 1'b1);
        last_addr = a;
      end else begin
        slave_xfer(8'($urandom), $urandom_range(0, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
